seg7_scan_ctrl: RTL and testbench

- Parametrised multiplexed 7-segment scan controller; next generation of the team's 8-digit hex display driver.
- Adds generic digit count and scan rate, per-digit decimal points, and tear-free double-buffered data load with handshake.
- Adds PWM brightness, per-digit blink and lamp test.
- Sits between CPU/debug register outputs and board anode/segment pins.

---
 rtl/seg7_scan_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment scan controller.
// Scans DIGITS common-anode digits, each slot lasting 2^DIV_BITS clocks.
// Display data is double buffered: a load request is latched and the shadow
// is only refreshed on the frame wrap, so a frame never shows mixed data.
// PWM brightness, per-digit blink and lamp test are applied live.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN blanks leading zero
// digits (the rightmost digit is never blanked).
module seg7_scan_ctrl #(
  parameter int DIGITS      = 8,
  parameter int DIV_BITS    = 11,
  parameter int BRIGHT_BITS = 3,
  parameter int BLINK_BITS  = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [4*DIGITS-1:0]        data,
  input  logic [DIGITS-1:0]          dp,
  input  logic                       load,
  output logic                       load_ack,
  input  logic [BRIGHT_BITS-1:0]     brightness,
  input  logic [DIGITS-1:0]          blink_mask,
  input  logic                       lamp_test,
  output logic [$clog2(DIGITS)-1:0]  which,
  output logic [DIGITS-1:0]          an,
  output logic [7:0]                 seg,
  output logic                       frame_start
);

  localparam int WB = $clog2(DIGITS);
  localparam logic [WB-1:0] LAST_DIG = WB'(DIGITS - 1);

  // Hex glyph table, segments {a,b,c,d,e,f,g}, active-low.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0:    g = 7'b0000001;
      4'h1:    g = 7'b1001111;
      4'h2:    g = 7'b0010010;
      4'h3:    g = 7'b0000110;
      4'h4:    g = 7'b1001100;
      4'h5:    g = 7'b0100100;
      4'h6:    g = 7'b0100000;
      4'h7:    g = 7'b0001111;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0000100;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b1100000;
      4'hC:    g = 7'b0110001;
      4'hD:    g = 7'b1000010;
      4'hE:    g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    return g;
  endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Blank mask indexed by digit number: zeros from digit 0 up to the first
  // non-zero nibble. The last digit is left out so an all-zero value still
  // shows a single "0".
  function automatic logic [DIGITS-1:0] lz_calc(input logic [4*DIGITS-1:0] d);
    logic [DIGITS-1:0] m;
    logic              seen;
    m    = '0;
    seen = 1'b0;
    for (int i = 0; i < DIGITS - 1; i++) begin
      if (!seen && (d[4*(DIGITS-1-i) +: 4] == 4'h0)) m[i] = 1'b1;
      else                                            seen = 1'b1;
    end
    return m;
  endfunction
`endif

  logic [DIV_BITS-1:0]   count_p0;
  logic [WB-1:0]         which_p0;
  logic [BLINK_BITS-1:0] frame_cnt;
  logic                  pending;
  logic [4*DIGITS-1:0]   shadow_data;
  logic [DIGITS-1:0]     shadow_dp;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0]     lz_mask;
`endif

  logic                  slot_end;
  logic                  wrap;
  logic                  capture;

  logic [3:0]            dig_nib;
  logic                  dig_dp;
  logic                  dig_blink;
  logic                  lz_blank;
  logic                  duty_on;
  logic                  blank;
  logic [DIGITS-1:0]     an_nxt;
  logic [7:0]            seg_nxt;
  logic [DIGITS-1:0]     an_p1;
  logic [7:0]            seg_p1;

  // Wrap is qualified by rst_n so no pulse escapes while reset is held.
  assign slot_end = &count_p0;
  assign wrap     = rst_n & slot_end & (which_p0 == LAST_DIG);
  assign capture  = wrap & (pending | load);

  // Scan timebase: free-running slot counter and digit index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_p0 <= '0;
      which_p0 <= '0;
    end else begin
      count_p0 <= count_p0 + DIV_BITS'(1);
      if (slot_end)
        which_p0 <= (which_p0 == LAST_DIG) ? '0 : which_p0 + WB'(1);
    end
  end

  // Frame counter drives the blink phase; advances once per full scan.
  always_ff @(posedge clk) begin
    if (!rst_n)    frame_cnt <= '0;
    else if (wrap) frame_cnt <= frame_cnt + BLINK_BITS'(1);
  end

  // Load handshake: latch requests, refresh the shadow only at frame wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending     <= 1'b0;
      shadow_data <= '0;
      shadow_dp   <= '0;
    end else begin
      if (wrap) pending <= 1'b0;
      else if (load) pending <= 1'b1;
      if (capture) begin
        shadow_data <= data;
        shadow_dp   <= dp;
      end
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Leading-zero mask follows the shadow, recomputed from the captured data.
  always_ff @(posedge clk) begin
    if (!rst_n)       lz_mask <= lz_calc('0);
    else if (capture) lz_mask <= lz_calc(data);
  end
`endif

  // Digit select, enable and segment pattern for the current count/which.
  always_comb begin
    dig_nib   = 4'h0;
    dig_dp    = 1'b0;
    dig_blink = 1'b0;
    lz_blank  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (which_p0 == WB'(i)) begin
        dig_nib   = shadow_data[4*(DIGITS-1-i) +: 4];
        dig_dp    = shadow_dp[DIGITS-1-i];
        dig_blink = blink_mask[DIGITS-1-i];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        lz_blank  = lz_mask[i];
`endif
      end
    end
    duty_on = (count_p0[DIV_BITS-1 -: BRIGHT_BITS] <= brightness);
    blank   = dig_blink & frame_cnt[BLINK_BITS-1];
    an_nxt  = '1;
    seg_nxt = 8'hFF;
    if (lamp_test) begin
      an_nxt  = ~(DIGITS'(1) << which_p0);
      seg_nxt = 8'h00;
    end else if (duty_on && !blank && !slot_end) begin
      an_nxt  = ~(DIGITS'(1) << which_p0);
      seg_nxt = lz_blank ? {7'h7F, ~dig_dp} : {glyph(dig_nib), ~dig_dp};
    end
  end

  // Output stage: registered anode/segment drive, dark in reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_p1  <= '1;
      seg_p1 <= 8'hFF;
    end else begin
      an_p1  <= an_nxt;
      seg_p1 <= seg_nxt;
    end
  end

  assign an          = an_p1;
  assign seg         = seg_p1;
  assign which       = which_p0;
  assign load_ack    = capture;
  assign frame_start = wrap;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl (DIGITS=4, DIV_BITS=4, BRIGHT_BITS=2, BLINK_BITS=2).
// Reference model tracks elapsed cycles since reset and derives slot, digit
// and frame with plain arithmetic.
module tb_seg7_scan_ctrl;
  localparam int DIGITS      = 4;
  localparam int DIV_BITS    = 4;
  localparam int BRIGHT_BITS = 2;
  localparam int BLINK_BITS  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0;
  logic        load_ack;
  logic [1:0]  brightness = 2'd3;
  logic [3:0]  blink_mask = '0;
  logic        lamp_test = 1'b0;
  logic [1:0]  which;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_start;

  int n_cmp = 0;
  int n_bad = 0;

  int unsigned mt = 0;
  logic [15:0] m_data = '0;
  logic [3:0]  m_dp = '0;
  bit          m_pend = 1'b0;

  seg7_scan_ctrl #(
    .DIGITS(DIGITS), .DIV_BITS(DIV_BITS),
    .BRIGHT_BITS(BRIGHT_BITS), .BLINK_BITS(BLINK_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .dp(dp), .load(load),
    .load_ack(load_ack), .brightness(brightness), .blink_mask(blink_mask),
    .lamp_test(lamp_test), .which(which), .an(an), .seg(seg),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic [6:0] glyph_ref(input logic [3:0] v);
    case (v)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, mt);
    end
  endtask

  // Expected drive for slot position cnt of digit wh in frame fc.
  task automatic model_out(input int cnt, input int wh, input int fc,
                           output logic [3:0] a, output logic [7:0] s);
    logic [3:0] nib;
    logic       dpb;
    logic       blk;
    nib = 4'(m_data >> (4 * (3 - wh)));
    dpb = m_dp[3 - wh];
    blk = blink_mask[3 - wh];
    a = 4'hF;
    s = 8'hFF;
    if (lamp_test) begin
      a = ~(4'b0001 << wh);
      s = 8'h00;
    end else if ((cnt / 4) <= int'(brightness) && !(blk && fc >= 2) && cnt != 15) begin
      a = ~(4'b0001 << wh);
      s = {glyph_ref(nib), ~dpb};
    end
  endtask

  // One clock: check combinational pulses mid-cycle, then registered outputs.
  task automatic cyc();
    int         cnt;
    int         wh;
    int         fc;
    bit         wrap;
    bit         ack;
    logic [3:0] ea;
    logic [7:0] es;
    @(negedge clk);
    cnt  = int'(mt % 16);
    wh   = int'((mt / 16) % 4);
    fc   = int'((mt / 64) % 4);
    wrap = rst_n && ((mt % 64) == 63);
    ack  = wrap && (m_pend || load);
    check("frame_start", 32'(frame_start), 32'(wrap));
    check("load_ack", 32'(load_ack), 32'(ack));
    model_out(cnt, wh, fc, ea, es);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      mt = 0; m_pend = 1'b0; m_data = '0; m_dp = '0;
      ea = 4'hF; es = 8'hFF;
    end else begin
      if (ack) begin
        m_data = data; m_dp = dp;
      end
      if (wrap) m_pend = 1'b0;
      else if (load) m_pend = 1'b1;
      mt++;
    end
    check("an", 32'(an), 32'(ea));
    check("seg", 32'(seg), 32'(es));
    check("which", 32'(which), (mt / 16) % 4);
  endtask

  task automatic run_until_phase(input int p);
    for (int k = 0; k < 64 && int'(mt % 64) != p; k++) cyc();
  endtask

  task automatic count_low(output int n);
    n = 0;
    for (int k = 0; k < 16; k++) begin
      cyc();
      if (an != 4'hF) n++;
    end
  endtask

  int nlow;

  initial begin
    // Reset held three cycles
    repeat (3) cyc();
    check("rst_an", 32'(an), 32'h0000000F);
    check("rst_seg", 32'(seg), 32'h000000FF);
    check("rst_which", 32'(which), 32'h0);
    rst_n = 1'b1;
    repeat (80) cyc();

    // Mid-frame single load, captured at the wrap
    run_until_phase(20);
    data = 16'h12AF; dp = 4'b0010; load = 1'b1;
    cyc();
    load = 1'b0;
    run_until_phase(63);
    #2;
    check("ack_on_wrap", 32'(load_ack), 32'h1);
    check("fs_on_wrap", 32'(frame_start), 32'h1);
    run_until_phase(8);
    check("digit0_seg", 32'(seg), 32'h9F);
    check("digit0_an", 32'(an), 32'hE);
    run_until_phase(24);
    check("digit1_seg", 32'(seg), 32'h25);
    check("digit1_an", 32'(an), 32'hD);
    run_until_phase(40);
    check("digit2_seg", 32'(seg), 32'h10);
    check("digit2_an", 32'(an), 32'hB);
    run_until_phase(56);
    check("digit3_seg", 32'(seg), 32'h71);
    check("digit3_an", 32'(an), 32'h7);

    // Brightness duty
    brightness = 2'd0;
    cyc();
    count_low(nlow);
    check("duty_b0", 32'(nlow), 32'd4);
    brightness = 2'd3;
    cyc();
    count_low(nlow);
    check("duty_b3", 32'(nlow), 32'd15);

    // Blink on digit 0 across four frames
    blink_mask = 4'b1000;
    for (int f = 0; f < 4; f++) begin
      run_until_phase(8);
      check("blink_d0", 32'(an), ((mt / 64) % 4 >= 2) ? 32'hF : 32'hE);
      run_until_phase(24);
      check("blink_d1", 32'(an), 32'hD);
    end

    // Lamp test overrides blink and brightness
    lamp_test = 1'b1; brightness = 2'd0; blink_mask = 4'hF;
    cyc();
    count_low(nlow);
    check("lamp_full_slot", 32'(nlow), 32'd16);
    repeat (200) cyc();
    lamp_test = 1'b0; blink_mask = 4'h0; brightness = 2'd3;

    // Randomized rounds with live data changes and sporadic loads
    for (int r = 0; r < 8; r++) begin
      dp         = 4'($urandom);
      brightness = 2'($urandom_range(0, 3));
      blink_mask = 4'($urandom);
      lamp_test  = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 120; k++) begin
        if ($urandom_range(0, 3) == 0) data = 16'($urandom);
        load = ($urandom_range(0, 15) == 0);
        cyc();
      end
      load = 1'b0;
    end

    // Reset mid-frame with a load pending
    lamp_test = 1'b0; blink_mask = 4'h0; brightness = 2'd3;
    data = 16'h9876; dp = 4'hF;
    run_until_phase(20);
    load = 1'b1;
    cyc();
    load = 1'b0;
    run_until_phase(40);
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    run_until_phase(63);
    #2;
    check("rst_no_ack", 32'(load_ack), 32'h0);
    run_until_phase(8);
    check("rst_shadow_zero", 32'(seg), 32'h03);
    repeat (40) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
